combat_arbiter: RTL and testbench

- Frame-rate combat controller between two player FSMs. Samples each player's animation state, hitbox and hurtbox once per frame tick, resolves hits both ways and applies damage.
- Owns health, hitstun and the round-over/winner decision.
- Sits beside the two player instances. The stun outputs gate player inputs; health and winner feed the pixel/overlay path.

---
 rtl/combat_pkg.sv | 41 ++++
 rtl/combat_arbiter_box_overlap.sv | 26 ++
 rtl/combat_arbiter.sv | 216 +++++++++++++++++++++
 tb/tb_combat_arbiter.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/combat_pkg.sv
// combat_pkg: player state codes, arbiter FSM states, box layout, winner codes.
// Boxes pack {x1,x2,y1,y2}, 10 bits each, inclusive corners.
package combat_pkg;

    typedef enum logic [3:0] {
        PS_IDLE      = 4'd0,
        PS_FWD       = 4'd1,
        PS_BACK      = 4'd2,
        PS_ATK_START = 4'd3,
        PS_ATK_END   = 4'd4,
        PS_ATK_PULL  = 4'd5
    } player_state_e;

    typedef enum logic [2:0] {
        ARB_FIGHT,
        ARB_SAMPLE,
        ARB_RESOLVE,
        ARB_APPLY,
        ARB_ROUND_OVER
    } arb_state_e;

    typedef enum logic [1:0] {
        WIN_NONE = 2'b00,
        WIN_P1   = 2'b01,
        WIN_P2   = 2'b10,
        WIN_DRAW = 2'b11
    } winner_e;

    localparam int BOX_W     = 40;
    localparam int COORD_W   = 10;
    localparam int BOX_X1_HI = 39;
    localparam int BOX_X1_LO = 30;
    localparam int BOX_X2_HI = 29;
    localparam int BOX_X2_LO = 20;
    localparam int BOX_Y1_HI = 19;
    localparam int BOX_Y1_LO = 10;
    localparam int BOX_Y2_HI = 9;
    localparam int BOX_Y2_LO = 0;
    localparam int STUN_W    = 8;

endpackage

// File: rtl/combat_arbiter_box_overlap.sv
// box_overlap: combinational inclusive-rectangle intersection test.
module box_overlap
    import combat_pkg::*;
(
    input  logic [BOX_W-1:0] a_i,
    input  logic [BOX_W-1:0] b_i,
    output logic             hit_o
);

    logic [COORD_W-1:0] ax1, ax2, ay1, ay2;
    logic [COORD_W-1:0] bx1, bx2, by1, by2;

    assign ax1 = a_i[BOX_X1_HI:BOX_X1_LO];
    assign ax2 = a_i[BOX_X2_HI:BOX_X2_LO];
    assign ay1 = a_i[BOX_Y1_HI:BOX_Y1_LO];
    assign ay2 = a_i[BOX_Y2_HI:BOX_Y2_LO];
    assign bx1 = b_i[BOX_X1_HI:BOX_X1_LO];
    assign bx2 = b_i[BOX_X2_HI:BOX_X2_LO];
    assign by1 = b_i[BOX_Y1_HI:BOX_Y1_LO];
    assign by2 = b_i[BOX_Y2_HI:BOX_Y2_LO];

    // Touching edges count as contact.
    assign hit_o = (ax1 <= bx2) && (bx1 <= ax2) &&
                   (ay1 <= by2) && (by1 <= ay2);

endmodule

// File: rtl/combat_arbiter.sv
// combat_arbiter: per-frame hit resolution, health, hitstun and round result.
// Define COMBAT_HIT_COUNT_EN to add the p1_hits/p2_hits landed-hit counters.
module combat_arbiter
    import combat_pkg::*;
#(
    parameter int unsigned HEALTH_W            = 4,
    parameter int unsigned MAX_HEALTH          = 3,
    parameter int unsigned HITSTUN_FRAMES      = 20,
    parameter logic [3:0]  ATTACK_ACTIVE_STATE = PS_ATK_END
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                frame_tick,
    input  logic                restart,
    input  logic [3:0]          p1_state,
    input  logic [3:0]          p2_state,
    input  logic [BOX_W-1:0]    p1_hit_box,
    input  logic [BOX_W-1:0]    p2_hit_box,
    input  logic [BOX_W-1:0]    p1_hurt_box,
    input  logic [BOX_W-1:0]    p2_hurt_box,
    output logic [HEALTH_W-1:0] p1_health,
    output logic [HEALTH_W-1:0] p2_health,
    output logic                p1_stun,
    output logic                p2_stun,
    output logic                p1_hit_pulse,
    output logic                p2_hit_pulse,
    output logic                round_over,
`ifdef COMBAT_HIT_COUNT_EN
    output logic [7:0]          p1_hits,
    output logic [7:0]          p2_hits,
`endif
    output logic [1:0]          winner
);

    localparam logic [HEALTH_W-1:0] HP_INIT   = HEALTH_W'(MAX_HEALTH);
    localparam logic [STUN_W-1:0]   STUN_INIT = STUN_W'(HITSTUN_FRAMES);

    arb_state_e state_q, state_d;
    logic [BOX_W-1:0] hit1_q, hit1_d, hurt1_q, hurt1_d;
    logic [BOX_W-1:0] hit2_q, hit2_d, hurt2_q, hurt2_d;
    logic [3:0] st1_q, st1_d, st2_q, st2_d;
    logic hit12_q, hit12_d, hit21_q, hit21_d;
    logic armed1_q, armed1_d, armed2_q, armed2_d;
    logic pulse1_q, pulse1_d, pulse2_q, pulse2_d;
    logic [HEALTH_W-1:0] hp1_q, hp1_d, hp2_q, hp2_d;
    logic [STUN_W-1:0] stun1_q, stun1_d, stun2_q, stun2_d;
    logic [1:0] winner_q, winner_d;
    logic ov12, ov21;
`ifdef COMBAT_HIT_COUNT_EN
    logic [7:0] hits1_q, hits1_d, hits2_q, hits2_d;
`endif

    box_overlap u_ov12 (.a_i(hit1_q), .b_i(hurt2_q), .hit_o(ov12));
    box_overlap u_ov21 (.a_i(hit2_q), .b_i(hurt1_q), .hit_o(ov21));

    always_comb begin
        state_d  = state_q;
        hit1_d   = hit1_q;
        hurt1_d  = hurt1_q;
        hit2_d   = hit2_q;
        hurt2_d  = hurt2_q;
        st1_d    = st1_q;
        st2_d    = st2_q;
        hit12_d  = hit12_q;
        hit21_d  = hit21_q;
        armed1_d = armed1_q;
        armed2_d = armed2_q;
        pulse1_d = 1'b0;
        pulse2_d = 1'b0;
        hp1_d    = hp1_q;
        hp2_d    = hp2_q;
        stun1_d  = stun1_q;
        stun2_d  = stun2_q;
        winner_d = winner_q;
`ifdef COMBAT_HIT_COUNT_EN
        hits1_d  = hits1_q;
        hits2_d  = hits2_q;
`endif
        unique case (state_q)
            ARB_FIGHT: begin
                if (frame_tick) begin
                    state_d = ARB_SAMPLE;
                    hit1_d  = p1_hit_box;
                    hurt1_d = p1_hurt_box;
                    hit2_d  = p2_hit_box;
                    hurt2_d = p2_hurt_box;
                    st1_d   = p1_state;
                    st2_d   = p2_state;
                    if (stun1_q != '0) stun1_d = stun1_q - 1'b1;
                    if (stun2_q != '0) stun2_d = stun2_q - 1'b1;
                end
            end
            ARB_SAMPLE: begin
                state_d = ARB_RESOLVE;
                hit12_d = (st1_q == ATTACK_ACTIVE_STATE) && armed1_q &&
                          (stun1_q == '0) && (stun2_q == '0) && ov12;
                hit21_d = (st2_q == ATTACK_ACTIVE_STATE) && armed2_q &&
                          (stun2_q == '0) && (stun1_q == '0) && ov21;
                // Leaving the active frame re-arms: one hit per swing.
                if (st1_q != ATTACK_ACTIVE_STATE) armed1_d = 1'b1;
                if (st2_q != ATTACK_ACTIVE_STATE) armed2_d = 1'b1;
            end
            ARB_RESOLVE: begin
                state_d = ARB_APPLY;
                if (hit12_q) begin
                    hp2_d    = (hp2_q == '0) ? '0 : hp2_q - 1'b1;
                    stun2_d  = STUN_INIT;
                    pulse2_d = 1'b1;
                    armed1_d = 1'b0;
`ifdef COMBAT_HIT_COUNT_EN
                    if (hits1_q != 8'hFF) hits1_d = hits1_q + 8'd1;
`endif
                end
                if (hit21_q) begin
                    hp1_d    = (hp1_q == '0) ? '0 : hp1_q - 1'b1;
                    stun1_d  = STUN_INIT;
                    pulse1_d = 1'b1;
                    armed2_d = 1'b0;
`ifdef COMBAT_HIT_COUNT_EN
                    if (hits2_q != 8'hFF) hits2_d = hits2_q + 8'd1;
`endif
                end
            end
            ARB_APPLY: begin
                state_d = ARB_FIGHT;
                if (hp1_q == '0 || hp2_q == '0) begin
                    state_d = ARB_ROUND_OVER;
                    if (hp1_q == '0 && hp2_q == '0) winner_d = WIN_DRAW;
                    else if (hp2_q == '0)           winner_d = WIN_P1;
                    else                            winner_d = WIN_P2;
                end
            end
            ARB_ROUND_OVER: begin
                if (restart) begin
                    state_d  = ARB_FIGHT;
                    hp1_d    = HP_INIT;
                    hp2_d    = HP_INIT;
                    stun1_d  = '0;
                    stun2_d  = '0;
                    armed1_d = 1'b1;
                    armed2_d = 1'b1;
                    winner_d = WIN_NONE;
`ifdef COMBAT_HIT_COUNT_EN
                    hits1_d  = '0;
                    hits2_d  = '0;
`endif
                end
            end
            default: state_d = ARB_FIGHT;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ARB_FIGHT;
            hit1_q   <= '0;
            hurt1_q  <= '0;
            hit2_q   <= '0;
            hurt2_q  <= '0;
            st1_q    <= '0;
            st2_q    <= '0;
            hit12_q  <= 1'b0;
            hit21_q  <= 1'b0;
            armed1_q <= 1'b1;
            armed2_q <= 1'b1;
            pulse1_q <= 1'b0;
            pulse2_q <= 1'b0;
            hp1_q    <= HP_INIT;
            hp2_q    <= HP_INIT;
            stun1_q  <= '0;
            stun2_q  <= '0;
            winner_q <= WIN_NONE;
`ifdef COMBAT_HIT_COUNT_EN
            hits1_q  <= '0;
            hits2_q  <= '0;
`endif
        end else begin
            state_q  <= state_d;
            hit1_q   <= hit1_d;
            hurt1_q  <= hurt1_d;
            hit2_q   <= hit2_d;
            hurt2_q  <= hurt2_d;
            st1_q    <= st1_d;
            st2_q    <= st2_d;
            hit12_q  <= hit12_d;
            hit21_q  <= hit21_d;
            armed1_q <= armed1_d;
            armed2_q <= armed2_d;
            pulse1_q <= pulse1_d;
            pulse2_q <= pulse2_d;
            hp1_q    <= hp1_d;
            hp2_q    <= hp2_d;
            stun1_q  <= stun1_d;
            stun2_q  <= stun2_d;
            winner_q <= winner_d;
`ifdef COMBAT_HIT_COUNT_EN
            hits1_q  <= hits1_d;
            hits2_q  <= hits2_d;
`endif
        end
    end

    assign p1_health    = hp1_q;
    assign p2_health    = hp2_q;
    assign p1_stun      = (stun1_q != '0);
    assign p2_stun      = (stun2_q != '0);
    assign p1_hit_pulse = pulse1_q;
    assign p2_hit_pulse = pulse2_q;
    assign round_over   = (state_q == ARB_ROUND_OVER);
    assign winner       = winner_q;
`ifdef COMBAT_HIT_COUNT_EN
    assign p1_hits      = hits1_q;
    assign p2_hits      = hits2_q;
`endif

endmodule

// File: tb/tb_combat_arbiter.sv
// tb_combat_arbiter: table-driven frame vectors with a scoreboard queue,
// plus hand sequences for restart and mid-pipeline reset.
module tb_combat_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        frame_tick;
    logic        restart;
    logic [3:0]  p1_state, p2_state;
    logic [39:0] p1_hit_box, p2_hit_box, p1_hurt_box, p2_hurt_box;
    logic [3:0]  p1_health, p2_health;
    logic        p1_stun, p2_stun, p1_hit_pulse, p2_hit_pulse;
    logic        round_over;
    logic [1:0]  winner;
`ifdef COMBAT_HIT_COUNT_EN
    logic [7:0]  p1_hits, p2_hits;
`endif

    combat_arbiter dut (
        .clk(clk), .rst(rst), .frame_tick(frame_tick), .restart(restart),
        .p1_state(p1_state), .p2_state(p2_state),
        .p1_hit_box(p1_hit_box), .p2_hit_box(p2_hit_box),
        .p1_hurt_box(p1_hurt_box), .p2_hurt_box(p2_hurt_box),
        .p1_health(p1_health), .p2_health(p2_health),
        .p1_stun(p1_stun), .p2_stun(p2_stun),
        .p1_hit_pulse(p1_hit_pulse), .p2_hit_pulse(p2_hit_pulse),
        .round_over(round_over),
`ifdef COMBAT_HIT_COUNT_EN
        .p1_hits(p1_hits), .p2_hits(p2_hits),
`endif
        .winner(winner)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          rb;
        int          reps;
        logic [3:0]  s1, s2;
        logic [39:0] h1, u1, h2, u2;
        bit          pu1, pu2;
        int          hp1, hp2;
        bit          st1, st2, ov;
        logic [1:0]  win;
    } vec_t;

    vec_t tv[25];
    vec_t sb[$];
    int errors = 0;
    int checks = 0;
    logic [39:0] FA, FB, HIT1, HURT2, TRA, TRB;

    function automatic logic [39:0] bx(input int x1, x2, y1, y2);
        return {10'(x1), 10'(x2), 10'(y1), 10'(y2)};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input vec_t v);
        p1_state    = v.s1;
        p2_state    = v.s2;
        p1_hit_box  = v.h1;
        p1_hurt_box = v.u1;
        p2_hit_box  = v.h2;
        p2_hurt_box = v.u2;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        frame_tick = 1'b0;
        restart = 1'b0;
        step();
        rst = 1'b1;
        step();
    endtask

    // Tick edge, then sample/resolve edge, then apply edge (pulse), then exit.
    task automatic run_frame(input vec_t v, input int row);
        vec_t e;
        drive(v);
        frame_tick = 1'b1;
        sb.push_back(v);
        step();
        frame_tick = 1'b0;
        step();
        chk($sformatf("r%0d early_pulse", row),
            {p1_hit_pulse, p2_hit_pulse}, 0);
        step();
        if (sb.size() == 0) begin
            chk($sformatf("r%0d sb_empty", row), 1, 0);
        end else begin
            e = sb.pop_front();
            chk($sformatf("r%0d p1_pulse", row), p1_hit_pulse, e.pu1);
            chk($sformatf("r%0d p2_pulse", row), p2_hit_pulse, e.pu2);
            chk($sformatf("r%0d p1_health", row), p1_health, e.hp1);
            chk($sformatf("r%0d p2_health", row), p2_health, e.hp2);
            step();
            chk($sformatf("r%0d late_pulse", row),
                {p1_hit_pulse, p2_hit_pulse}, 0);
            chk($sformatf("r%0d p1_stun", row), p1_stun, e.st1);
            chk($sformatf("r%0d p2_stun", row), p2_stun, e.st2);
            chk($sformatf("r%0d round_over", row), round_over, e.ov);
            chk($sformatf("r%0d winner", row), winner, e.win);
        end
    endtask

    task automatic run_rows(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            if (tv[i].rb) do_reset();
            for (int r = 0; r < tv[i].reps; r++) run_frame(tv[i], i);
        end
    endtask

    initial begin
        FA    = bx(0, 10, 0, 10);
        FB    = bx(500, 510, 500, 510);
        HIT1  = bx(200, 260, 100, 150);
        HURT2 = bx(250, 400, 80, 237);
        TRA   = bx(100, 200, 100, 200);
        TRB   = bx(150, 250, 150, 250);
        // rb reps s1 s2 h1 u1 h2 u2 pu1 pu2 hp1 hp2 st1 st2 ov win
        tv[0]  = '{0, 10, 0, 0, FA, FA, FB, FB, 0, 0, 3, 3, 0, 0, 0, 0};
        tv[1]  = '{0, 1, 4, 0, HIT1, FA, FB, HURT2, 0, 1, 3, 2, 0, 1, 0, 0};
        tv[2]  = '{0, 4, 4, 0, HIT1, FA, FB, HURT2, 0, 0, 3, 2, 0, 1, 0, 0};
        tv[3]  = '{0, 15, 5, 0, HIT1, FA, FB, HURT2, 0, 0, 3, 2, 0, 1, 0, 0};
        tv[4]  = '{0, 1, 5, 0, HIT1, FA, FB, HURT2, 0, 0, 3, 2, 0, 0, 0, 0};
        tv[5]  = '{0, 1, 4, 0, HIT1, FA, FB, HURT2, 0, 1, 3, 1, 0, 1, 0, 0};
        tv[6]  = '{1, 1, 4, 0, bx(200, 249, 100, 150), FA, FB, HURT2,
                   0, 0, 3, 3, 0, 0, 0, 0};
        tv[7]  = '{0, 1, 4, 0, bx(200, 260, 40, 79), FA, FB, HURT2,
                   0, 0, 3, 3, 0, 0, 0, 0};
        tv[8]  = '{0, 1, 4, 0, bx(200, 250, 100, 150), FA, FB, HURT2,
                   0, 1, 3, 2, 0, 1, 0, 0};
        tv[9]  = '{1, 1, 4, 4, TRA, TRA, TRB, TRB, 1, 1, 2, 2, 1, 1, 0, 0};
        tv[10] = '{0, 19, 0, 0, TRA, TRA, TRB, TRB, 0, 0, 2, 2, 1, 1, 0, 0};
        tv[11] = '{0, 1, 0, 0, TRA, TRA, TRB, TRB, 0, 0, 2, 2, 0, 0, 0, 0};
        tv[12] = '{0, 1, 4, 4, TRA, TRA, TRB, TRB, 1, 1, 1, 1, 1, 1, 0, 0};
        tv[13] = '{0, 19, 0, 0, TRA, TRA, TRB, TRB, 0, 0, 1, 1, 1, 1, 0, 0};
        tv[14] = '{0, 1, 0, 0, TRA, TRA, TRB, TRB, 0, 0, 1, 1, 0, 0, 0, 0};
        tv[15] = '{0, 1, 4, 4, TRA, TRA, TRB, TRB, 1, 1, 0, 0, 1, 1, 1, 3};
        tv[16] = '{0, 3, 4, 4, TRA, TRA, TRB, TRB, 0, 0, 0, 0, 1, 1, 1, 3};
        tv[17] = '{0, 1, 4, 4, TRA, TRA, TRB, TRB, 1, 1, 2, 2, 1, 1, 0, 0};
        tv[18] = '{1, 1, 0, 4, FA, HURT2, HIT1, FB, 1, 0, 2, 3, 1, 0, 0, 0};
        tv[19] = '{0, 19, 0, 0, FA, HURT2, HIT1, FB, 0, 0, 2, 3, 1, 0, 0, 0};
        tv[20] = '{0, 1, 0, 0, FA, HURT2, HIT1, FB, 0, 0, 2, 3, 0, 0, 0, 0};
        tv[21] = '{0, 1, 0, 4, FA, HURT2, HIT1, FB, 1, 0, 1, 3, 1, 0, 0, 0};
        tv[22] = '{0, 19, 0, 0, FA, HURT2, HIT1, FB, 0, 0, 1, 3, 1, 0, 0, 0};
        tv[23] = '{0, 1, 0, 0, FA, HURT2, HIT1, FB, 0, 0, 1, 3, 0, 0, 0, 0};
        tv[24] = '{0, 1, 0, 4, FA, HURT2, HIT1, FB, 1, 0, 0, 3, 1, 0, 1, 2};

        rst = 1'b0;
        frame_tick = 1'b0;
        restart = 1'b0;
        drive(tv[0]);
        step();
        step();
        chk("rst p1_health", p1_health, 3);
        chk("rst p2_health", p2_health, 3);
        chk("rst stun", {p1_stun, p2_stun}, 0);
        chk("rst pulse", {p1_hit_pulse, p2_hit_pulse}, 0);
        chk("rst round_over", round_over, 0);
        chk("rst winner", winner, 0);
        rst = 1'b1;
        step();

        run_rows(0, 16);

        // Restart and tick on one edge: restart wins, tick dropped.
        restart = 1'b1;
        frame_tick = 1'b1;
        step();
        restart = 1'b0;
        frame_tick = 1'b0;
        chk("restart round_over", round_over, 0);
        chk("restart winner", winner, 0);
        chk("restart health", {p1_health, p2_health}, 8'h33);
        chk("restart stun", {p1_stun, p2_stun}, 0);
        for (int k = 0; k < 3; k++) begin
            step();
            chk($sformatf("dropped_tick pulse%0d", k),
                {p1_hit_pulse, p2_hit_pulse}, 0);
        end

        run_rows(17, 17);

        // Restart outside ROUND_OVER has no effect.
        restart = 1'b1;
        step();
        restart = 1'b0;
        step();
        chk("fight_restart health", {p1_health, p2_health}, 8'h22);
        chk("fight_restart stun", {p1_stun, p2_stun}, 2'b11);

        run_rows(18, 24);

        // Async reset mid-cycle from ROUND_OVER: outputs clear at once.
        #2 rst = 1'b0;
        #1;
        chk("async round_over", round_over, 0);
        chk("async winner", winner, 0);
        chk("async p1_health", p1_health, 3);
        chk("async p1_stun", p1_stun, 0);
        step();
        rst = 1'b1;
        step();

        // Reset while a hit is pending in RESOLVE: no pulse follows.
        drive(tv[1]);
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
        step();
        #2 rst = 1'b0;
        #1;
        for (int k = 0; k < 4; k++) begin
            if (k == 2) rst = 1'b1;
            chk($sformatf("midpipe pulse%0d", k),
                {p1_hit_pulse, p2_hit_pulse}, 0);
            chk($sformatf("midpipe p2_health%0d", k), p2_health, 3);
            step();
        end

        run_rows(1, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
